multi_cycle_ctrl: RTL and testbench

Multi-cycle control unit for the multi-cycle revision of `Data_path`, which adds `pc_we` and `ir_we` enables. Fetches each instruction through a request/acknowledge memory handshake and decodes the MIPS subset. It then walks the datapath through FETCH/DECODE/EXEC/MEM/WB, driving the existing control inputs (`Jump`, `RegWrite`, `RegDst`, `MentoReg`, `ALU_Control`, `ALUSrc_B`, `Branch`, `inst_field`). Faults (illegal opcode, memory timeout) park the core in HALT until reset.

---
 rtl/ctrl_pkg.sv | 67 ++++++
 rtl/multi_cycle_ctrl_if.sv | 21 ++
 rtl/alu_dec.sv | 36 +++
 rtl/multi_cycle_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for multi_cycle_ctrl: FSM states, MIPS opcodes and functs,
// ALU_Control codes, fault codes and opcode classification.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        FAULT_NONE    = 2'b00,
        FAULT_ILLEGAL = 2'b01,
        FAULT_TIMEOUT = 2'b10
    } fault_t;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_J,
        CLS_BEQ,
        CLS_ADDI,
        CLS_SLTI,
        CLS_LW,
        CLS_SW,
        CLS_ILLEGAL
    } op_class_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    function automatic op_class_t classify(input logic [5:0] opcode);
        case (opcode)
            OP_RTYPE: return CLS_R;
            OP_J:     return CLS_J;
            OP_BEQ:   return CLS_BEQ;
            OP_ADDI:  return CLS_ADDI;
            OP_SLTI:  return CLS_SLTI;
            OP_LW:    return CLS_LW;
            OP_SW:    return CLS_SW;
            default:  return CLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Instruction/data memory handshake between the controller (master) and memory (slave).
interface multi_cycle_ctrl_if;
    logic [31:0] inst;
    logic        mem_ack;
    logic        mem_req;
    logic        mem_we;

    modport master (
        output mem_req,
        output mem_we,
        input  inst,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        output inst,
        output mem_ack
    );
endinterface

// File: rtl/alu_dec.sv
// Combinational ALU decoder: opcode class plus funct to ALU_Control, with a
// legal flag that rejects unknown opcodes and unknown R-type functs.
module alu_dec
    import ctrl_pkg::*;
(
    input  op_class_t   op_class,
    input  logic [5:0]  funct,
    output logic [2:0]  alu_ctrl,
    output logic        legal
);

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        alu_ctrl = ALU_AND;
        legal    = 1'b1;
        case (op_class)
            CLS_R: begin
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_NOR:  alu_ctrl = ALU_NOR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: legal    = 1'b0;
                endcase
            end
            CLS_ADDI, CLS_LW, CLS_SW: alu_ctrl = ALU_ADD;
            CLS_SLTI:                 alu_ctrl = ALU_SLT;
            CLS_BEQ:                  alu_ctrl = ALU_SUB;
            CLS_J:                    alu_ctrl = ALU_AND;
            default:                  legal    = 1'b0;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with
// memory timeout and illegal-opcode faults. Optional CTRL_PERF_CNT_EN adds instret/cycles.
module multi_cycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic               clk,
    input  logic               rst,
    multi_cycle_ctrl_if.master mem,
    input  logic               zero,
    output logic               ir_we,
    output logic               pc_we,
    output logic               Jump,
    output logic               RegWrite,
    output logic               RegDst,
    output logic               MentoReg,
    output logic               ALUSrc_B,
    output logic               Branch,
    output logic [2:0]         ALU_Control,
    output logic [25:0]        inst_field,
    output logic [2:0]         state,
    output logic [1:0]         fault
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]        instret,
    output logic [31:0]        cycles
`endif
);

    // wait_cnt counts request cycles already spent without ack; the last allowed one is WAIT_LAST.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t     state_q, state_d;
    fault_t     fault_q, fault_d;
    logic [5:0] opcode_q, funct_q;
    logic [7:0] wait_cnt;
    op_class_t  op_class;
    logic [2:0] alu_code;
    logic       op_legal;
    logic       timeout;

    assign op_class = classify(opcode_q);
    assign timeout  = (wait_cnt == WAIT_LAST) && !mem.mem_ack;
    assign state    = state_q;
    assign fault    = fault_q;

    alu_dec u_alu_dec (
        .op_class (op_class),
        .funct    (funct_q),
        .alu_ctrl (alu_code),
        .legal    (op_legal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the decode registers are reset too; inst_field is visible and must read 0 out of reset.
            state_q    <= ST_IDLE;
            fault_q    <= FAULT_NONE;
            wait_cnt   <= '0;
            opcode_q   <= '0;
            funct_q    <= '0;
            inst_field <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            fault_q <= fault_d;
            if (state_d != state_q)
                wait_cnt <= '0;
            else if (state_q == ST_FETCH || state_q == ST_MEM)
                wait_cnt <= wait_cnt + 8'd1;
            if (ir_we) begin
                opcode_q   <= mem.inst[31:26];
                funct_q    <= mem.inst[5:0];
                inst_field <= mem.inst[25:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        fault_d     = fault_q;
        mem.mem_req = 1'b0;
        mem.mem_we  = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        Jump        = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        MentoReg    = 1'b0;
        ALUSrc_B    = 1'b0;
        Branch      = 1'b0;
        ALU_Control = ALU_AND;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                mem.mem_req = 1'b1;
                if (mem.mem_ack) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = ST_DECODE;
                end else if (timeout) begin
                    fault_d = FAULT_TIMEOUT;
                    state_d = ST_HALT;
                end
            end
            ST_DECODE: begin
                if (op_legal) begin
                    state_d = ST_EXEC;
                end else begin
                    fault_d = FAULT_ILLEGAL;
                    state_d = ST_HALT;
                end
            end
            ST_EXEC: begin
                ALU_Control = alu_code;
                case (op_class)
                    CLS_R:              state_d = ST_WB;
                    CLS_ADDI, CLS_SLTI: begin
                        ALUSrc_B = 1'b1;
                        state_d  = ST_WB;
                    end
                    CLS_LW, CLS_SW: begin
                        ALUSrc_B = 1'b1;
                        state_d  = ST_MEM;
                    end
                    CLS_BEQ: begin
                        Branch  = 1'b1;
                        pc_we   = zero;
                        state_d = ST_FETCH;
                    end
                    CLS_J: begin
                        Jump    = 1'b1;
                        pc_we   = 1'b1;
                        state_d = ST_FETCH;
                    end
                    default: begin
                        fault_d = FAULT_ILLEGAL;
                        state_d = ST_HALT;
                    end
                endcase
            end
            ST_MEM: begin
                // Address path stays selected for the whole access.
                ALU_Control = alu_code;
                ALUSrc_B    = 1'b1;
                mem.mem_req = 1'b1;
                mem.mem_we  = (op_class == CLS_SW);
                if (mem.mem_ack) begin
                    state_d = (op_class == CLS_SW) ? ST_FETCH : ST_WB;
                end else if (timeout) begin
                    fault_d = FAULT_TIMEOUT;
                    state_d = ST_HALT;
                end
            end
            ST_WB: begin
                // ALU operands are held so the unregistered ALU result is still valid at write-back.
                ALU_Control = alu_code;
                ALUSrc_B    = (op_class != CLS_R);
                RegWrite    = 1'b1;
                RegDst      = (op_class == CLS_R);
                MentoReg    = (op_class == CLS_LW);
                state_d     = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef CTRL_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instret <= '0;
            cycles  <= '0;
        end else begin
            if (state_d == ST_FETCH &&
                (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB))
                instret <= instret + 32'd1;
            if (state_q != ST_IDLE && state_q != ST_HALT)
                cycles <= cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: stimulus pushes per-cycle expected outputs,
// a negedge monitor pops and compares them. Perf counters checked when CTRL_PERF_CNT_EN is set.
module tb_multi_cycle_ctrl;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3;
    localparam logic [2:0] S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd7;

    // {Branch, ALUSrc_B, MentoReg, RegDst, RegWrite, Jump, pc_we, ir_we, mem_we, mem_req}
    localparam logic [9:0] F_REQ  = 10'b0000000001;
    localparam logic [9:0] F_WE   = 10'b0000000010;
    localparam logic [9:0] F_IR   = 10'b0000000100;
    localparam logic [9:0] F_PC   = 10'b0000001000;
    localparam logic [9:0] F_JMP  = 10'b0000010000;
    localparam logic [9:0] F_RW   = 10'b0000100000;
    localparam logic [9:0] F_RD   = 10'b0001000000;
    localparam logic [9:0] F_M2R  = 10'b0010000000;
    localparam logic [9:0] F_SRCB = 10'b0100000000;
    localparam logic [9:0] F_BR   = 10'b1000000000;
    localparam logic [9:0] F_NONE = 10'b0000000000;

    localparam logic [2:0] A_AND = 3'b000, A_ADD = 3'b010, A_NOR = 3'b100;
    localparam logic [2:0] A_SUB = 3'b110, A_SLT = 3'b111;
    localparam logic [1:0] FL_NONE = 2'b00, FL_ILL = 2'b01, FL_TMO = 2'b10;

    localparam logic [31:0] ADD_I   = 32'h012A4020;
    localparam logic [31:0] SUB_I   = 32'h012A4022;
    localparam logic [31:0] AND_I   = 32'h012A4024;
    localparam logic [31:0] NOR_I   = 32'h012A4027;
    localparam logic [31:0] BADFN_I = 32'h012A4021;
    localparam logic [31:0] LW_I    = 32'h8D090004;
    localparam logic [31:0] SW_I    = 32'hAD090008;
    localparam logic [31:0] BEQ_I   = 32'h11090003;
    localparam logic [31:0] J_I     = 32'h08000010;
    localparam logic [31:0] ADDI_I  = 32'h21280005;
    localparam logic [31:0] SLTI_I  = 32'h29280005;
    localparam logic [31:0] ILL_I   = 32'hFC000000;

    typedef struct {
        string       name;
        logic [2:0]  st;
        logic [9:0]  fl;
        logic [2:0]  alu;
        logic [1:0]  flt;
        logic [25:0] fld;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [25:0] cur_field;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        zero = 1'b0;
    logic        ir_we, pc_we, Jump, RegWrite, RegDst, MentoReg, ALUSrc_B, Branch;
    logic [2:0]  ALU_Control;
    logic [25:0] inst_field;
    logic [2:0]  state;
    logic [1:0]  fault;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] instret, cycles;
`endif

    multi_cycle_ctrl_if mem ();

    multi_cycle_ctrl #(.TIMEOUT_CYC(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem         (mem.master),
        .zero        (zero),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .Jump        (Jump),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .MentoReg    (MentoReg),
        .ALUSrc_B    (ALUSrc_B),
        .Branch      (Branch),
        .ALU_Control (ALU_Control),
        .inst_field  (inst_field),
        .state       (state),
        .fault       (fault)
`ifdef CTRL_PERF_CNT_EN
        ,
        .instret     (instret),
        .cycles      (cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one expected record per cycle, compared at the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name,
                  64'({state, Branch, ALUSrc_B, MentoReg, RegDst, RegWrite, Jump, pc_we, ir_we,
                       mem.mem_we, mem.mem_req, ALU_Control, fault, inst_field}),
                  64'({e.st, e.fl, e.alu, e.flt, e.fld}));
        end
    end

    task automatic cyc(input logic r, input logic a, input logic [31:0] i, input logic z,
                       input string nm, input logic [2:0] st, input logic [9:0] fl,
                       input logic [2:0] alu, input logic [1:0] flt);
        exp_t e;
        rst         = r;
        mem.mem_ack = a;
        mem.inst    = i;
        zero        = z;
        e.name = nm; e.st = st; e.fl = fl; e.alu = alu; e.flt = flt; e.fld = cur_field;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cur_field = '0;
        cyc(1'b0, 1'b0, 32'h0, 1'b0, "reset", S_IDLE, F_NONE, A_AND, FL_NONE);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, "idle", S_IDLE, F_NONE, A_AND, FL_NONE);
    endtask

    // Decode is driven with a stray ack, which must be ignored.
    task automatic fetch(input logic [31:0] i, input int waits);
        for (int k = 0; k < waits; k++)
            cyc(1'b1, 1'b0, i, 1'b0, "fetch_wait", S_FETCH, F_REQ, A_AND, FL_NONE);
        cyc(1'b1, 1'b1, i, 1'b0, "fetch_ack", S_FETCH, F_REQ | F_IR | F_PC, A_AND, FL_NONE);
        cur_field = i[25:0];
        cyc(1'b1, 1'b1, i, 1'b0, "decode", S_DECODE, F_NONE, A_AND, FL_NONE);
    endtask

    task automatic run_r(input logic [31:0] i, input logic [2:0] alu, input int waits);
        fetch(i, waits);
        cyc(1'b1, 1'b0, i, 1'b0, "r_exec", S_EXEC, F_NONE, alu, FL_NONE);
        cyc(1'b1, 1'b0, i, 1'b0, "r_wb", S_WB, F_RW | F_RD, alu, FL_NONE);
    endtask

    task automatic run_i(input logic [31:0] i, input logic [2:0] alu, input int waits);
        fetch(i, waits);
        cyc(1'b1, 1'b0, i, 1'b0, "i_exec", S_EXEC, F_SRCB, alu, FL_NONE);
        cyc(1'b1, 1'b0, i, 1'b0, "i_wb", S_WB, F_RW | F_SRCB, alu, FL_NONE);
    endtask

    task automatic run_lw(input logic [31:0] i, input int waits);
        fetch(i, 0);
        cyc(1'b1, 1'b0, i, 1'b0, "lw_exec", S_EXEC, F_SRCB, A_ADD, FL_NONE);
        for (int k = 0; k < waits; k++)
            cyc(1'b1, 1'b0, i, 1'b0, "lw_mem_wait", S_MEM, F_REQ | F_SRCB, A_ADD, FL_NONE);
        cyc(1'b1, 1'b1, i, 1'b0, "lw_mem_ack", S_MEM, F_REQ | F_SRCB, A_ADD, FL_NONE);
        cyc(1'b1, 1'b0, i, 1'b0, "lw_wb", S_WB, F_RW | F_M2R | F_SRCB, A_ADD, FL_NONE);
    endtask

    task automatic run_sw(input logic [31:0] i);
        fetch(i, 0);
        cyc(1'b1, 1'b0, i, 1'b0, "sw_exec", S_EXEC, F_SRCB, A_ADD, FL_NONE);
        cyc(1'b1, 1'b1, i, 1'b0, "sw_mem", S_MEM, F_REQ | F_WE | F_SRCB, A_ADD, FL_NONE);
    endtask

    task automatic run_beq(input logic [31:0] i, input logic z);
        fetch(i, 0);
        cyc(1'b1, 1'b0, i, z, "beq_exec", S_EXEC, F_BR | (z ? F_PC : F_NONE), A_SUB, FL_NONE);
    endtask

    task automatic run_j(input logic [31:0] i);
        fetch(i, 0);
        cyc(1'b1, 1'b0, i, 1'b0, "j_exec", S_EXEC, F_JMP | F_PC, A_AND, FL_NONE);
    endtask

    initial begin
        mem.mem_ack = 1'b0;
        mem.inst    = 32'h0;
        cur_field   = '0;
        @(posedge clk);
        #1;

        do_reset();
        run_r(ADD_I, A_ADD, 0);
        run_lw(LW_I, 3);
        run_sw(SW_I);
        run_beq(BEQ_I, 1'b1);
        run_beq(BEQ_I, 1'b0);
        run_j(J_I);
        run_i(ADDI_I, A_ADD, 2);
        run_i(SLTI_I, A_SLT, 0);
        run_r(NOR_I, A_NOR, 0);

        // Reset asserted during write-back aborts the instruction at once.
        fetch(ADD_I, 0);
        cyc(1'b1, 1'b0, ADD_I, 1'b0, "r_exec", S_EXEC, F_NONE, A_ADD, FL_NONE);
        cur_field = '0;
        cyc(1'b0, 1'b0, ADD_I, 1'b0, "rst_in_wb", S_IDLE, F_NONE, A_AND, FL_NONE);
        cyc(1'b1, 1'b0, ADD_I, 1'b0, "idle", S_IDLE, F_NONE, A_AND, FL_NONE);

        // Illegal opcode parks in HALT; acks are ignored there.
        fetch(ILL_I, 0);
        for (int k = 0; k < 20; k++)
            cyc(1'b1, 1'(k & 1), ILL_I, 1'b0, "halt_illegal_op", S_HALT, F_NONE, A_AND, FL_ILL);
        do_reset();

        fetch(BADFN_I, 0);
        cyc(1'b1, 1'b0, BADFN_I, 1'b0, "halt_illegal_fn", S_HALT, F_NONE, A_AND, FL_ILL);
        cyc(1'b1, 1'b1, BADFN_I, 1'b0, "halt_illegal_fn", S_HALT, F_NONE, A_AND, FL_ILL);
        do_reset();

        // Fetch timeout: 15 request cycles, then HALT with fault 10.
        for (int k = 0; k < 15; k++)
            cyc(1'b1, 1'b0, ADD_I, 1'b0, "fetch_timeout_wait", S_FETCH, F_REQ, A_AND, FL_NONE);
        for (int k = 0; k < 4; k++)
            cyc(1'b1, 1'b1, ADD_I, 1'b0, "halt_timeout", S_HALT, F_NONE, A_AND, FL_TMO);
        do_reset();

        // Ack on the final allowed cycle wins over the timeout.
        run_r(SUB_I, A_SUB, 14);
        do_reset();

        run_r(ADD_I, A_ADD, 0);
        run_r(SUB_I, A_SUB, 0);
        run_r(AND_I, A_AND, 0);
`ifdef CTRL_PERF_CNT_EN
        check("instret", 64'(instret), 64'(3));
        check("cycles", 64'(cycles), 64'(12));
`endif
        check("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
